vid_timing_pattern_gen: RTL and testbench



---
 rtl/vid_pkg.sv | 68 ++++++
 rtl/vid_pattern_px.sv | 71 +++++++
 rtl/vid_timing_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_vid_timing_pattern_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// -----------------------------------------------------------------------------
// vid_pkg
// Shared definitions for the pixel-clock video source:
//   - CEA 1280x720p60 timing constants (defaults for the timing generator)
//   - pattern_e: test-pattern selector encoding
//   - 24-bit colour constants in the {R, B, G} byte order of the TMDS encoder
//   - rgb_pack / bar_colour helpers
// -----------------------------------------------------------------------------
package vid_pkg;

  // 720p60 timing (pixels / lines)
  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 110;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;

  // Raster counter width; wide enough for 1650 pixels and 750 lines.
  localparam int COORD_W = 12;

  // Moving-bar geometry
  localparam int BAR_LEN  = 16;
  localparam int BAR_STEP = 4;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_BAR   = 2'd3
  } pattern_e;

  // Colours as {R, B, G}
  localparam logic [23:0] COL_WHITE   = 24'hFF_FF_FF;
  localparam logic [23:0] COL_YELLOW  = 24'hFF_00_FF;
  localparam logic [23:0] COL_CYAN    = 24'h00_FF_FF;
  localparam logic [23:0] COL_GREEN   = 24'h00_00_FF;
  localparam logic [23:0] COL_MAGENTA = 24'hFF_FF_00;
  localparam logic [23:0] COL_RED     = 24'hFF_00_00;
  localparam logic [23:0] COL_BLUE    = 24'h00_FF_00;
  localparam logic [23:0] COL_BLACK   = 24'h00_00_00;

  // The encoder expects blue in the middle byte and green in the low byte.
  function automatic logic [23:0] rgb_pack(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, b, g};
  endfunction

  // Colour of vertical bar idx, left (0) to right (7).
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_pattern_px.sv
// -----------------------------------------------------------------------------
// vid_pattern_px
// Combinational test-pattern pixel function.
//   x, y       : pixel coordinate inside the active area
//   sel        : pattern (bars, grey ramp, checkerboard, moving bar)
//   bar_pos    : left edge of the moving bar for the current frame
//   frame_cnt  : completed-frame count (bit 5 inverts the checkerboard)
//   pixel      : 24-bit {R, B, G} colour
// -----------------------------------------------------------------------------
module vid_pattern_px
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  pattern_e           sel,
  input  logic [10:0]        bar_pos,
  input  logic [7:0]         frame_cnt,
  output logic [23:0]        pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [7:1]         past_edge;
  logic [2:0]         bar_idx;
  logic [COORD_W-1:0] bar_lo;
  logic [COORD_W-1:0] bar_hi;
  logic               checker_white;
  logic               in_bar;
  logic               unused_bits;

  // Bar width need not be a power of two, so the bar index comes from
  // seven constant threshold compares instead of a divider.
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
      assign past_edge[gi] = (x >= COORD_W'(gi * BAR_W));
    end
  endgenerate

  // Thresholds are monotonic, so the highest one passed is the bar index.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (past_edge[i]) bar_idx = 3'(i);
    end
  end

  // Bar end is computed one bit wider than bar_pos so it never wraps
  // back to the left edge of the screen.
  assign bar_lo = COORD_W'(bar_pos);
  assign bar_hi = bar_lo + COORD_W'(BAR_LEN);
  assign in_bar = (x >= bar_lo) && (x < bar_hi);

  // Origin square is white; the whole board inverts every 32 frames.
  assign checker_white = ~(x[5] ^ y[5] ^ frame_cnt[5]);

  assign unused_bits = ^{y[COORD_W-1:6], y[4:0], frame_cnt[7:6], frame_cnt[4:0]};

  always_comb begin
    pixel = COL_BLACK;
    case (sel)
      PAT_BARS:  pixel = bar_colour(bar_idx);
      PAT_RAMP:  pixel = rgb_pack(x[10:3], x[10:3], x[10:3]);
      PAT_CHECK: pixel = checker_white ? COL_WHITE : COL_BLACK;
      PAT_BAR:   pixel = in_bar ? COL_WHITE : COL_BLACK;
      default:   pixel = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/vid_timing_pattern_gen.sv
// -----------------------------------------------------------------------------
// vid_timing_pattern_gen
// Raster timing generator plus test-pattern source driving the TMDS encoder.
//   PixelClk     : pixel clock, all logic on rising edge
//   pRst         : synchronous active-high reset (priority over pEnable)
//   pEnable      : run enable; low holds the raster at the origin, outputs idle
//   pPatternSel  : pattern select, latched at the start of each frame
//   vid_pData    : {R, B, G} pixel, zero outside active video
//   vid_pVDE     : active-video flag
//   vid_pHSync   : horizontal sync, asserted level = SYNC_POL
//   vid_pVSync   : vertical sync, asserted level = SYNC_POL
//   pFrameStart  : one-cycle pulse with the first active pixel of a frame
//   pFrameCnt    : completed frames, wraps 255 -> 0
// All outputs are registered and describe the raster position held in the
// counters on the previous cycle.
// -----------------------------------------------------------------------------
module vid_timing_pattern_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACTIVE = V_ACTIVE_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720,
  parameter int SYNC_POL = 1
) (
  input  logic        PixelClk,
  input  logic        pRst,
  input  logic        pEnable,
  input  logic [1:0]  pPatternSel,
  output logic [23:0] vid_pData,
  output logic        vid_pVDE,
  output logic        vid_pHSync,
  output logic        vid_pVSync,
  output logic        pFrameStart,
  output logic [7:0]  pFrameCnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG_C = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END_C = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] H_LAST_C = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_BEG_C = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END_C = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_LAST_C = COORD_W'(V_TOTAL - 1);
  localparam logic [10:0]        BAR_STEP_C  = 11'(BAR_STEP);
  localparam logic [10:0]        BAR_LIMIT_C = 11'(H_ACTIVE);
  localparam logic               SYNC_ON  = (SYNC_POL != 0);
  localparam logic               SYNC_OFF = ~SYNC_ON;

  // Raster state
  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [10:0]        bar_pos_q, bar_pos_d;
  pattern_e           pat_q, pat_d;

  // Output registers
  logic [23:0]        data_q, data_d;
  logic               vde_q, vde_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               fs_q, fs_d;

  // Decode of the current raster position
  logic               at_origin;
  logic               h_wrap;
  logic               v_wrap;
  logic               frame_wrap;
  logic               active;
  logic               hs_on;
  logic               vs_on;
  logic [10:0]        bar_sum;
  pattern_e           pat_eff;
  logic [23:0]        pix;

  assign at_origin  = (h_q == '0) && (v_q == '0);
  assign h_wrap     = (h_q == H_LAST_C);
  assign v_wrap     = (v_q == V_LAST_C);
  assign frame_wrap = h_wrap && v_wrap;
  assign active     = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hs_on      = (h_q >= HS_BEG_C) && (h_q < HS_END_C);
  // v only changes at h wrap, so vsync naturally spans whole lines.
  assign vs_on      = (v_q >= VS_BEG_C) && (v_q < VS_END_C);
  assign bar_sum    = bar_pos_q + BAR_STEP_C;

  // The selector is taken live at the origin so the very first pixel of a
  // frame already shows the newly selected pattern; elsewhere it is held.
  assign pat_eff = at_origin ? pattern_e'(pPatternSel) : pat_q;

  vid_pattern_px #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_px (
    .x         (h_q),
    .y         (v_q),
    .sel       (pat_eff),
    .bar_pos   (bar_pos_q),
    .frame_cnt (frame_cnt_q),
    .pixel     (pix)
  );

  always_comb begin
    // Disabled: raster parked at the origin, outputs idle, frame state held.
    h_d         = '0;
    v_d         = '0;
    frame_cnt_d = frame_cnt_q;
    bar_pos_d   = bar_pos_q;
    pat_d       = pat_q;
    data_d      = '0;
    vde_d       = 1'b0;
    hs_d        = SYNC_OFF;
    vs_d        = SYNC_OFF;
    fs_d        = 1'b0;

    if (pEnable) begin
      h_d = h_wrap ? '0 : h_q + COORD_W'(1);
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + COORD_W'(1);
      end else begin
        v_d = v_q;
      end

      // Frame counter and bar position advance together so the next frame's
      // first pixel already sees the new values.
      if (frame_wrap) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        bar_pos_d   = (bar_sum >= BAR_LIMIT_C) ? '0 : bar_sum;
      end

      pat_d  = pat_eff;
      data_d = active ? pix : '0;
      vde_d  = active;
      hs_d   = hs_on ? SYNC_ON : SYNC_OFF;
      vs_d   = vs_on ? SYNC_ON : SYNC_OFF;
      fs_d   = at_origin;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (pRst) begin
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      bar_pos_q   <= '0;
      pat_q       <= PAT_BARS;
      data_q      <= '0;
      vde_q       <= 1'b0;
      hs_q        <= SYNC_OFF;
      vs_q        <= SYNC_OFF;
      fs_q        <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      bar_pos_q   <= bar_pos_d;
      pat_q       <= pat_d;
      data_q      <= data_d;
      vde_q       <= vde_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
    end
  end

  assign vid_pData   = data_q;
  assign vid_pVDE    = vde_q;
  assign vid_pHSync  = hs_q;
  assign vid_pVSync  = vs_q;
  assign pFrameStart = fs_q;
  assign pFrameCnt   = frame_cnt_q;

endmodule

// File: tb/tb_vid_timing_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vid_timing_pattern_gen
// Instance A: full 1650-pixel line timing, shortened frame (6 lines),
//             active-high syncs.
// Instance B: small raster (48 x 38, 40 x 34 active), active-low syncs, used
//             for multi-frame behaviour (checkerboard rows, moving bar wrap).
// -----------------------------------------------------------------------------
module tb_vid_timing_pattern_gen;

  localparam int A_HT = 1650;
  localparam int A_VT = 6;
  localparam int B_HT = 48;
  localparam int B_VT = 38;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [1:0]  sel_a, sel_b;
  logic [23:0] a_data, b_data;
  logic        a_vde, a_hs, a_vs, a_fs;
  logic        b_vde, b_hs, b_vs, b_fs;
  logic [7:0]  a_fcnt, b_fcnt;

  int checks = 0;
  int passed = 0;

  // Raster position trackers: counter state and the pixel now on the outputs.
  int a_ch = 0, a_cv = 0, a_oh = 0, a_ov = 0;
  int b_ch = 0, b_cv = 0, b_oh = 0, b_ov = 0;
  bit a_ok = 0, b_ok = 0;

  always #5 clk = ~clk;

  vid_timing_pattern_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
  ) dut_a (
    .PixelClk(clk), .pRst(rst), .pEnable(en_a), .pPatternSel(sel_a),
    .vid_pData(a_data), .vid_pVDE(a_vde), .vid_pHSync(a_hs), .vid_pVSync(a_vs),
    .pFrameStart(a_fs), .pFrameCnt(a_fcnt)
  );

  vid_timing_pattern_gen #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
  ) dut_b (
    .PixelClk(clk), .pRst(rst), .pEnable(en_b), .pPatternSel(sel_b),
    .vid_pData(b_data), .vid_pVDE(b_vde), .vid_pHSync(b_hs), .vid_pVSync(b_vs),
    .pFrameStart(b_fs), .pFrameCnt(b_fcnt)
  );

  task automatic tick();
    logic r, ea, eb;
    r = rst; ea = en_a; eb = en_b;
    @(posedge clk);
    #1;
    if (r || !ea) begin
      a_ch = 0; a_cv = 0; a_ok = 0;
    end else begin
      a_oh = a_ch; a_ov = a_cv; a_ok = 1;
      if (a_ch == A_HT - 1) begin a_ch = 0; a_cv = (a_cv == A_VT - 1) ? 0 : a_cv + 1; end
      else a_ch++;
    end
    if (r || !eb) begin
      b_ch = 0; b_cv = 0; b_ok = 0;
    end else begin
      b_oh = b_ch; b_ov = b_cv; b_ok = 1;
      if (b_ch == B_HT - 1) begin b_ch = 0; b_cv = (b_cv == B_VT - 1) ? 0 : b_cv + 1; end
      else b_ch++;
    end
  endtask

  task automatic goto_a(input int h, input int v);
    int n = 0;
    while (!(a_ok && a_oh == h && a_ov == v) && n < 20000) begin tick(); n++; end
  endtask

  task automatic goto_b(input int h, input int v);
    int n = 0;
    while (!(b_ok && b_oh == h && b_ov == v) && n < 5000) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b1; en_b = 1'b0; sel_a = 2'd0; sel_b = 2'd2;
    repeat (3) tick();
    checks++; if (a_vde !== 1'b0) $display("FAIL rst_vde got=%b want=0", a_vde); else passed++;
    checks++; if (a_data !== 24'h0) $display("FAIL rst_data got=%h want=000000", a_data); else passed++;
    checks++; if (a_hs !== 1'b0 || a_vs !== 1'b0) $display("FAIL rst_sync_a got=%b%b want=00", a_hs, a_vs); else passed++;
    checks++; if (a_fs !== 1'b0) $display("FAIL rst_fs got=%b want=0", a_fs); else passed++;
    checks++; if (a_fcnt !== 8'd0) $display("FAIL rst_fcnt got=%0d want=0", a_fcnt); else passed++;
    checks++; if (b_hs !== 1'b1 || b_vs !== 1'b1 || b_vde !== 1'b0) $display("FAIL rst_idle_b got hs=%b vs=%b vde=%b want 1 1 0", b_hs, b_vs, b_vde); else passed++;
    rst = 1'b0;
    checks++; if (a_vde !== 1'b0) $display("FAIL release_idle got=%b want=0", a_vde); else passed++;
    $display("test_reset: done, %0d checks so far", checks);
  endtask

  task automatic test_bars();
    tick();
    checks++; if (a_vde !== 1'b1 || a_fs !== 1'b1) $display("FAIL first_px vde=%b fs=%b want 1 1", a_vde, a_fs); else passed++;
    checks++; if (a_data !== 24'hFFFFFF) $display("FAIL bars_x0 got=%h want=ffffff", a_data); else passed++;
    tick();
    checks++; if (a_fs !== 1'b0) $display("FAIL fs_pulse got=%b want=0", a_fs); else passed++;
    goto_a(159, 0);
    checks++; if (a_data !== 24'hFFFFFF) $display("FAIL bars_x159 got=%h want=ffffff", a_data); else passed++;
    goto_a(160, 0);
    checks++; if (a_data !== 24'hFF00FF) $display("FAIL bars_x160 got=%h want=ff00ff", a_data); else passed++;
    goto_a(960, 0);
    checks++; if (a_data !== 24'h00FF00) $display("FAIL bars_x960 got=%h want=00ff00", a_data); else passed++;
    goto_a(1120, 0);
    checks++; if (a_data !== 24'h000000 || a_vde !== 1'b1) $display("FAIL bars_x1120 got=%h vde=%b want=000000 1", a_data, a_vde); else passed++;
    goto_a(1280, 0);
    checks++; if (a_vde !== 1'b0 || a_data !== 24'h0) $display("FAIL blank_x1280 vde=%b data=%h want 0 000000", a_vde, a_data); else passed++;
    $display("test_bars: done, %0d checks so far", checks);
  endtask

  task automatic test_line_timing();
    int vde_n = 0, hs_n = 0, vs_n = 0, hs_first = -1, blank_bad = 0;
    goto_a(0, 1);
    for (int i = 0; i < A_HT; i++) begin
      if (a_vde === 1'b1) vde_n++;
      else if (a_data !== 24'h0) blank_bad++;
      if (a_hs === 1'b1) begin hs_n++; if (hs_first < 0) hs_first = i; end
      if (a_vs === 1'b1) vs_n++;
      if (i < A_HT - 1) tick();
    end
    checks++; if (vde_n != 1280) $display("FAIL line_vde got=%0d want=1280", vde_n); else passed++;
    checks++; if (hs_n != 40) $display("FAIL line_hs_len got=%0d want=40", hs_n); else passed++;
    checks++; if (hs_first != 1390) $display("FAIL line_hs_start got=%0d want=1390", hs_first); else passed++;
    checks++; if (vs_n != 0) $display("FAIL line_vs got=%0d want=0", vs_n); else passed++;
    checks++; if (blank_bad != 0) $display("FAIL blank_data got=%0d want=0", blank_bad); else passed++;
    $display("test_line_timing: done, %0d checks so far", checks);
  endtask

  task automatic test_frame_timing();
    int vde_n = 0, hs_n = 0, vs_n = 0, vs_first = -1, fs_n = 0;
    goto_a(0, 0);
    checks++; if (a_fs !== 1'b1 || a_fcnt !== 8'd1) $display("FAIL frame1_start fs=%b fcnt=%0d want 1 1", a_fs, a_fcnt); else passed++;
    for (int i = 0; i < A_HT * A_VT; i++) begin
      if (a_vde === 1'b1) vde_n++;
      if (a_hs === 1'b1) hs_n++;
      if (a_fs === 1'b1) fs_n++;
      if (a_vs === 1'b1) begin vs_n++; if (vs_first < 0) vs_first = i; end
      if (i < A_HT * A_VT - 1) tick();
    end
    checks++; if (vde_n != 2560) $display("FAIL frame_vde got=%0d want=2560", vde_n); else passed++;
    checks++; if (hs_n != 240) $display("FAIL frame_hs got=%0d want=240", hs_n); else passed++;
    checks++; if (vs_n != 3300) $display("FAIL frame_vs_len got=%0d want=3300", vs_n); else passed++;
    checks++; if (vs_first != 4950) $display("FAIL frame_vs_start got=%0d want=4950", vs_first); else passed++;
    checks++; if (fs_n != 1) $display("FAIL frame_fs_count got=%0d want=1", fs_n); else passed++;
    tick();
    checks++; if (a_fs !== 1'b1 || a_fcnt !== 8'd2) $display("FAIL frame_period fs=%b fcnt=%0d want 1 2", a_fs, a_fcnt); else passed++;
    $display("test_frame_timing: done, %0d checks so far", checks);
  endtask

  task automatic test_ramp();
    sel_a = 2'd1;
    goto_a(160, 0);
    checks++; if (a_data !== 24'hFF00FF) $display("FAIL latch_hold got=%h want=ff00ff", a_data); else passed++;
    tick();
    goto_a(0, 0);
    checks++; if (a_data !== 24'h0 || a_vde !== 1'b1 || a_fcnt !== 8'd3) $display("FAIL ramp_x0 data=%h vde=%b fcnt=%0d want 000000 1 3", a_data, a_vde, a_fcnt); else passed++;
    goto_a(8, 0);
    checks++; if (a_data !== 24'h010101) $display("FAIL ramp_x8 got=%h want=010101", a_data); else passed++;
    goto_a(1279, 0);
    checks++; if (a_data !== 24'h9F9F9F) $display("FAIL ramp_x1279 got=%h want=9f9f9f", a_data); else passed++;
    goto_a(800, 1);
    checks++; if (a_data !== 24'h646464) $display("FAIL ramp_x800 got=%h want=646464", a_data); else passed++;
    $display("test_ramp: done, %0d checks so far", checks);
  endtask

  task automatic test_enable_low();
    int idle_bad = 0, hold_bad = 0;
    en_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (a_vde !== 1'b0 || a_data !== 24'h0 || a_hs !== 1'b0 || a_vs !== 1'b0 || a_fs !== 1'b0) idle_bad++;
      if (a_fcnt !== 8'd3) hold_bad++;
    end
    checks++; if (idle_bad != 0) $display("FAIL disable_idle bad_cycles=%0d want=0", idle_bad); else passed++;
    checks++; if (hold_bad != 0) $display("FAIL disable_fcnt_hold bad_cycles=%0d want=0 (fcnt=%0d)", hold_bad, a_fcnt); else passed++;
    sel_a = 2'd0; en_a = 1'b1;
    checks++; if (a_vde !== 1'b0) $display("FAIL reenable_idle got=%b want=0", a_vde); else passed++;
    tick();
    checks++; if (a_fs !== 1'b1 || a_vde !== 1'b1) $display("FAIL reenable_start fs=%b vde=%b want 1 1", a_fs, a_vde); else passed++;
    checks++; if (a_data !== 24'hFFFFFF || a_fcnt !== 8'd3) $display("FAIL reenable_px data=%h fcnt=%0d want ffffff 3", a_data, a_fcnt); else passed++;
    en_a = 1'b0;
    tick();
    $display("test_enable_low: done, %0d checks so far", checks);
  endtask

  task automatic test_checker();
    sel_b = 2'd2; en_b = 1'b1;
    tick();
    checks++; if (b_fs !== 1'b1 || b_data !== 24'hFFFFFF) $display("FAIL chk_0_0 fs=%b data=%h want 1 ffffff", b_fs, b_data); else passed++;
    checks++; if (b_hs !== 1'b1 || b_fcnt !== 8'd0) $display("FAIL b_start hs=%b fcnt=%0d want 1 0", b_hs, b_fcnt); else passed++;
    goto_b(32, 0);
    checks++; if (b_data !== 24'h0) $display("FAIL chk_32_0 got=%h want=000000", b_data); else passed++;
    goto_b(0, 32);
    checks++; if (b_data !== 24'h0) $display("FAIL chk_0_32 got=%h want=000000", b_data); else passed++;
    goto_b(32, 32);
    checks++; if (b_data !== 24'hFFFFFF) $display("FAIL chk_32_32 got=%h want=ffffff", b_data); else passed++;
    $display("test_checker: done, %0d checks so far", checks);
  endtask

  task automatic test_pattern_latch();
    sel_b = 2'd3;
    goto_b(33, 33);
    checks++; if (b_data !== 24'hFFFFFF) $display("FAIL latch_midframe got=%h want=ffffff", b_data); else passed++;
    goto_b(0, 35);
    checks++; if (b_vs !== 1'b0) $display("FAIL b_vsync got=%b want=0", b_vs); else passed++;
    goto_b(0, 0);
    checks++; if (b_data !== 24'h0 || b_fcnt !== 8'd1) $display("FAIL bar_f1_x0 data=%h fcnt=%0d want 000000 1", b_data, b_fcnt); else passed++;
    goto_b(3, 0);
    checks++; if (b_data !== 24'h0) $display("FAIL bar_f1_x3 got=%h want=000000", b_data); else passed++;
    goto_b(4, 0);
    checks++; if (b_data !== 24'hFFFFFF) $display("FAIL bar_f1_x4 got=%h want=ffffff", b_data); else passed++;
    goto_b(19, 0);
    checks++; if (b_data !== 24'hFFFFFF) $display("FAIL bar_f1_x19 got=%h want=ffffff", b_data); else passed++;
    goto_b(20, 0);
    checks++; if (b_data !== 24'h0) $display("FAIL bar_f1_x20 got=%h want=000000", b_data); else passed++;
    goto_b(42, 0);
    checks++; if (b_hs !== 1'b0) $display("FAIL b_hsync_on got=%b want=0", b_hs); else passed++;
    goto_b(44, 0);
    checks++; if (b_hs !== 1'b1) $display("FAIL b_hsync_off got=%b want=1", b_hs); else passed++;
    $display("test_pattern_latch: done, %0d checks so far", checks);
  endtask

  task automatic test_bar_wrap();
    repeat (8) begin tick(); goto_b(0, 0); end
    checks++; if (b_fcnt !== 8'd9) $display("FAIL bar_f9_fcnt got=%0d want=9", b_fcnt); else passed++;
    goto_b(35, 0);
    checks++; if (b_data !== 24'h0) $display("FAIL bar_f9_x35 got=%h want=000000", b_data); else passed++;
    goto_b(36, 0);
    checks++; if (b_data !== 24'hFFFFFF) $display("FAIL bar_f9_x36 got=%h want=ffffff", b_data); else passed++;
    goto_b(39, 0);
    checks++; if (b_data !== 24'hFFFFFF) $display("FAIL bar_f9_x39 got=%h want=ffffff", b_data); else passed++;
    goto_b(0, 1);
    checks++; if (b_data !== 24'h0) $display("FAIL bar_no_wrap got=%h want=000000", b_data); else passed++;
    goto_b(0, 0);
    checks++; if (b_data !== 24'hFFFFFF || b_fcnt !== 8'd10) $display("FAIL bar_wrap_x0 data=%h fcnt=%0d want ffffff 10", b_data, b_fcnt); else passed++;
    goto_b(16, 0);
    checks++; if (b_data !== 24'h0) $display("FAIL bar_wrap_x16 got=%h want=000000", b_data); else passed++;
    tick();
    goto_b(0, 0);
    checks++; if (b_data !== 24'h0) $display("FAIL bar_f11_x0 got=%h want=000000", b_data); else passed++;
    $display("test_bar_wrap: done, %0d checks so far", checks);
  endtask

  task automatic test_reset_mid();
    goto_b(20, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b_vde !== 1'b0 || b_data !== 24'h0 || b_fs !== 1'b0) $display("FAIL midrst_idle vde=%b data=%h fs=%b want 0 000000 0", b_vde, b_data, b_fs); else passed++;
    checks++; if (b_hs !== 1'b1 || b_vs !== 1'b1) $display("FAIL midrst_sync hs=%b vs=%b want 1 1", b_hs, b_vs); else passed++;
    checks++; if (b_fcnt !== 8'd0 || a_fcnt !== 8'd0) $display("FAIL midrst_fcnt b=%0d a=%0d want 0 0", b_fcnt, a_fcnt); else passed++;
    tick();
    checks++; if (b_fs !== 1'b1 || b_vde !== 1'b1) $display("FAIL restart_start fs=%b vde=%b want 1 1", b_fs, b_vde); else passed++;
    checks++; if (b_data !== 24'hFFFFFF || b_fcnt !== 8'd0) $display("FAIL restart_bar0 data=%h fcnt=%0d want ffffff 0", b_data, b_fcnt); else passed++;
    goto_b(16, 0);
    checks++; if (b_data !== 24'h0) $display("FAIL restart_x16 got=%h want=000000", b_data); else passed++;
    $display("test_reset_mid: done, %0d checks so far", checks);
  endtask

  initial begin
    test_reset();
    test_bars();
    test_line_timing();
    test_frame_timing();
    test_ramp();
    test_enable_low();
    test_checker();
    test_pattern_latch();
    test_bar_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
